// File: rtl/rate_tick_gen_pkg.sv
// rate_tick_gen_pkg: state encoding and standard tick periods shared by selector and generator
package rate_tick_gen_pkg;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_STEP = 2'd2;
  typedef enum logic [1:0] {IDLE = ST_IDLE, RUN = ST_RUN, STEP = ST_STEP} state_t;
  localparam int unsigned PERIOD_SLOW = 5_000_000;
  localparam int unsigned PERIOD_MED  = 2_500_000;
  localparam int unsigned PERIOD_FAST = 1_250_000;
endpackage

// File: rtl/rate_tick_gen_if.sv
// rate_tick_gen_if: control inputs and tick outputs of the tick generator
interface rate_tick_gen_if #(
  parameter int PERIOD_W = 32,
  parameter int COUNT_W  = 16
);
  logic [PERIOD_W-1:0] period;
  logic                en;
  logic                step_req;
  logic                clear;
  logic                tick;
  logic [COUNT_W-1:0]  tick_count;
  logic                busy;
  modport master (output period, en, step_req, clear, input tick, tick_count, busy);
  modport slave  (input period, en, step_req, clear, output tick, tick_count, busy);
endinterface

// File: rtl/rate_tick_gen_period_counter.sv
// rate_tick_gen_period_counter: loadable down-counter with zero flag
module rate_tick_gen_period_counter #(
  parameter int PERIOD_W = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                load_i,
  input  logic                dec_i,
  input  logic [PERIOD_W-1:0] load_val_i,
  output logic                zero_o
);
  logic [PERIOD_W-1:0] cnt_q, cnt_d;
  // load wins over decrement; otherwise the count holds
  always_comb cnt_d = load_i ? load_val_i : dec_i ? cnt_q - PERIOD_W'(1) : cnt_q;
  // counter register
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign zero_o = cnt_q == '0;
endmodule

// File: rtl/rate_tick_gen.sv
// rate_tick_gen: period-driven tick enable generator with free-run and single-step modes
module rate_tick_gen #(
  parameter int PERIOD_W = 32,
  parameter int COUNT_W  = 16
) (
  input  logic          clk,
  input  logic          reset,
  rate_tick_gen_if.slave bus
);
  import rate_tick_gen_pkg::*;
  state_t              state_q, state_d;
  logic [PERIOD_W-1:0] period_q, period_d, p_eff, load_val;
  logic [COUNT_W-1:0]  tick_count_q, tick_count_d;
  logic                tick_q, fire, load, dec, zero, idle, active, counting, exit_run, p_chg;
  // clear beats a period change, which beats the normal count; leaving RUN freezes the counter
  always_comb begin
    p_eff        = (bus.period == '0) ? PERIOD_W'(1) : bus.period;
    idle         = state_q == IDLE;
    active       = state_q == RUN || state_q == STEP;
    exit_run     = state_q == RUN && !bus.en;
    counting     = active && !exit_run;
    p_chg        = p_eff != period_q;
    fire         = counting && !bus.clear && !p_chg && zero;
    load         = idle ? (bus.en || bus.step_req) : counting && (bus.clear || p_chg || zero);
    dec          = counting && !load;
    load_val     = (idle || (!bus.clear && p_chg)) ? p_eff - PERIOD_W'(1) : period_q - PERIOD_W'(1);
    state_d      = idle ? (bus.en ? RUN : bus.step_req ? STEP : IDLE) :
                   (!active || exit_run || (fire && state_q == STEP)) ? IDLE : state_q;
    period_d     = (idle || (counting && !bus.clear && p_chg)) ? p_eff : period_q;
    tick_count_d = bus.clear ? '0 : tick_count_q + COUNT_W'(fire);
  end
  // FSM state, latched period and registered tick outputs
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state_q      <= IDLE;
      period_q     <= PERIOD_W'(1);
      tick_q       <= 1'b0;
      tick_count_q <= '0;
    end else begin
      state_q      <= state_d;
      period_q     <= period_d;
      tick_q       <= fire;
      tick_count_q <= tick_count_d;
    end
  rate_tick_gen_period_counter #(.PERIOD_W(PERIOD_W)) u_cnt (
    .clk       (clk),
    .reset     (reset),
    .load_i    (load),
    .dec_i     (dec),
    .load_val_i(load_val),
    .zero_o    (zero)
  );
  assign bus.tick       = tick_q;
  assign bus.tick_count = tick_count_q;
  assign bus.busy       = active;
endmodule

// File: tb/tb_rate_tick_gen.sv
// tb_rate_tick_gen: scoreboard bench for the tick generator
module tb_rate_tick_gen;
  logic clk = 1'b0;
  logic reset = 1'b1;
  rate_tick_gen_if #(.PERIOD_W(32), .COUNT_W(16)) bus ();
  rate_tick_gen #(.PERIOD_W(32), .COUNT_W(16)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  typedef struct {logic tick; logic [15:0] cnt; logic busy;} exp_t;
  exp_t exp_q[$];
  int checks = 0;
  int errors = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic push(input logic t, input logic [15:0] c, input logic b);
    exp_t e;
    e.tick = t;
    e.cnt  = c;
    e.busy = b;
    exp_q.push_back(e);
  endtask
  task automatic edge_chk(input string tag);
    exp_t e;
    @(posedge clk);
    #1;
    check({tag, "_sb"}, exp_q.size(), 1);
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      check({tag, "_tick"}, bus.tick, e.tick);
      check({tag, "_cnt"}, bus.tick_count, e.cnt);
      check({tag, "_busy"}, bus.busy, e.busy);
    end
  endtask
  task automatic cyc(input logic t, input logic [15:0] c, input logic b, input string tag);
    push(t, c, b);
    edge_chk(tag);
  endtask
  initial begin
    bus.period = 4;
    bus.en = 0;
    bus.step_req = 0;
    bus.clear = 0;
    #12;
    check("rst_tick", bus.tick, 0);
    check("rst_cnt", bus.tick_count, 0);
    check("rst_busy", bus.busy, 0);
    reset = 0;
    @(posedge clk);
    #1;
    bus.en = 1;
    for (int k = 0; k <= 12; k++) begin
      push(k > 0 && k % 4 == 0, 16'(k / 4), 1);
      edge_chk("run4");
    end
    bus.en = 0;
    cyc(0, 3, 0, "run4_stop");
    bus.clear = 1;
    cyc(0, 0, 0, "clr1");
    bus.clear = 0;
    bus.period = 0;
    bus.en = 1;
    for (int k = 0; k <= 65537; k++) begin
      push(k > 0, 16'(k), 1);
      edge_chk("p0");
    end
    bus.en = 0;
    cyc(0, 1, 0, "p0_stop");
    bus.clear = 1;
    cyc(0, 0, 0, "clr2");
    bus.clear = 0;
    bus.period = 3;
    bus.step_req = 1;
    cyc(0, 0, 1, "step_e0");
    cyc(0, 0, 1, "step_e1");
    bus.step_req = 0;
    cyc(0, 0, 1, "step_e2");
    cyc(1, 1, 0, "step_e3");
    cyc(0, 1, 0, "step_e4");
    cyc(0, 1, 0, "step_e5");
    bus.clear = 1;
    cyc(0, 0, 0, "clr3");
    bus.clear = 0;
    bus.period = 10;
    bus.en = 1;
    for (int k = 0; k <= 14; k++) begin
      if (k == 5) bus.period = 3;
      push(k >= 8 && (k - 8) % 3 == 0, k < 8 ? 16'd0 : 16'((k - 8) / 3 + 1), 1);
      edge_chk("pchg");
    end
    bus.en = 0;
    cyc(0, 3, 0, "pchg_stop");
    bus.period = 5;
    bus.en = 1;
    for (int k = 0; k <= 10; k++) begin
      bus.clear = k == 3;
      push(k == 8, k < 3 ? 16'd3 : (k < 8 ? 16'd0 : 16'd1), 1);
      edge_chk("clr_run");
    end
    bus.clear = 0;
    bus.en = 0;
    cyc(0, 1, 0, "freeze_e0");
    cyc(0, 1, 0, "freeze_e1");
    bus.en = 1;
    for (int k = 0; k <= 5; k++) begin
      push(k == 5, k == 5 ? 16'd2 : 16'd1, 1);
      edge_chk("reentry");
    end
    bus.en = 0;
    cyc(0, 2, 0, "reentry_stop");
    bus.clear = 1;
    cyc(0, 0, 0, "clr4");
    bus.clear = 0;
    bus.period = 2;
    bus.en = 1;
    for (int k = 0; k <= 8; k++) begin
      if (k == 2) bus.period = 3;
      push(k == 5 || k == 8, k < 5 ? 16'd0 : (k < 8 ? 16'd1 : 16'd2), 1);
      edge_chk("pchg_zero");
    end
    bus.en = 0;
    cyc(0, 2, 0, "pchg_zero_stop");
    bus.clear = 1;
    cyc(0, 0, 0, "clr5");
    bus.clear = 0;
    bus.period = 2;
    bus.en = 1;
    for (int k = 0; k <= 2; k++) begin
      push(k == 2, k == 2 ? 16'd1 : 16'd0, 1);
      edge_chk("pre_arst");
    end
    #3;
    reset = 1;
    #1;
    check("arst_tick", bus.tick, 0);
    check("arst_cnt", bus.tick_count, 0);
    check("arst_busy", bus.busy, 0);
    @(posedge clk);
    #1;
    check("arst_hold_tick", bus.tick, 0);
    check("arst_hold_busy", bus.busy, 0);
    #2;
    reset = 0;
    cyc(0, 0, 1, "resume_e0");
    cyc(0, 0, 1, "resume_e1");
    cyc(1, 1, 1, "resume_e2");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
